// File: rtl/ysyx_mem_arb_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the memory port.
// slave is the arbiter view; master is the requester/memory side.
interface ysyx_mem_arb_if #(
    parameter int BIT_W = 32
);
    logic             ifu_avalid;
    logic [BIT_W-1:0] ifu_addr;
    logic             ifu_rvalid_o;
    logic [BIT_W-1:0] ifu_rdata_o;
    logic             ifu_err_o;

    logic             lsu_avalid;
    logic [BIT_W-1:0] lsu_addr;
    logic             lsu_wen;
    logic [BIT_W-1:0] lsu_wdata;
    logic             lsu_rvalid_o;
    logic             lsu_wready_o;
    logic [BIT_W-1:0] lsu_rdata_o;
    logic             lsu_err_o;

    logic             mem_avalid_o;
    logic [BIT_W-1:0] mem_addr_o;
    logic             mem_wen_o;
    logic [BIT_W-1:0] mem_wdata_o;
    logic             mem_rvalid;
    logic             mem_wready;
    logic [BIT_W-1:0] mem_rdata;

    modport slave (
        input  ifu_avalid, ifu_addr,
        output ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
        input  lsu_avalid, lsu_addr, lsu_wen, lsu_wdata,
        output lsu_rvalid_o, lsu_wready_o, lsu_rdata_o, lsu_err_o,
        output mem_avalid_o, mem_addr_o, mem_wen_o, mem_wdata_o,
        input  mem_rvalid, mem_wready, mem_rdata
    );

    modport master (
        output ifu_avalid, ifu_addr,
        input  ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
        output lsu_avalid, lsu_addr, lsu_wen, lsu_wdata,
        input  lsu_rvalid_o, lsu_wready_o, lsu_rdata_o, lsu_err_o,
        input  mem_avalid_o, mem_addr_o, mem_wen_o, mem_wdata_o,
        output mem_rvalid, mem_wready, mem_rdata
    );
endinterface

// File: rtl/ysyx_mem_arb.sv
// IFU/LSU single-port memory arbiter: LSU priority with an IFU
// anti-starvation cap, one outstanding transaction, response watchdog.
module ysyx_mem_arb #(
    parameter int BIT_W          = 32,
    parameter int LSU_MAX_STREAK = 4,
    parameter int TIMEOUT_CYC    = 255
) (
    input logic            clk,
    input logic            rst,
    ysyx_mem_arb_if.slave  bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IFU_BUSY = 2'd1;
    localparam logic [1:0] LSU_BUSY = 2'd2;

    localparam logic [2:0] STREAK_MAX = 3'(LSU_MAX_STREAK);
    localparam bit         TMO_EN     = (TIMEOUT_CYC != 0);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       streak_q, streak_d;
    logic [7:0]       timer_q, timer_d;
    logic [BIT_W-1:0] addr_q, addr_d;
    logic [BIT_W-1:0] wdata_q, wdata_d;
    logic             wen_q, wen_d;

    logic ifu_busy, lsu_busy, busy;
    logic done, tmo, resp;
    logic gnt_ifu, gnt_lsu;

    assign ifu_busy = (state_q == IFU_BUSY);
    assign lsu_busy = (state_q == LSU_BUSY);
    assign busy     = ifu_busy | lsu_busy;

    // Only the strobe matching the transaction direction completes it.
    assign done = (ifu_busy & bus.mem_rvalid)
                | (lsu_busy & (wen_q ? bus.mem_wready : bus.mem_rvalid));
    assign tmo  = busy & TMO_EN & (timer_q == TMO_LAST) & ~done;
    assign resp = done | tmo;

    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (state_q == IDLE) begin
            if (bus.ifu_avalid &&
                (!bus.lsu_avalid || streak_q == STREAK_MAX))
                gnt_ifu = 1'b1;
            else if (bus.lsu_avalid)
                gnt_lsu = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = wen_q;
        case (state_q)
            IDLE: begin
                if (gnt_lsu) begin
                    state_d  = LSU_BUSY;
                    addr_d   = bus.lsu_addr;
                    wen_d    = bus.lsu_wen;
                    wdata_d  = bus.lsu_wdata;
                    timer_d  = 8'd0;
                    if (!bus.ifu_avalid)
                        streak_d = 3'd0;
                    else if (streak_q != 3'd7)
                        streak_d = streak_q + 3'd1;
                end else if (gnt_ifu) begin
                    state_d  = IFU_BUSY;
                    addr_d   = bus.ifu_addr;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    timer_d  = 8'd0;
                    streak_d = 3'd0;
                end
            end
            IFU_BUSY, LSU_BUSY: begin
                if (resp)
                    state_d = IDLE;
                else if (TMO_EN)
                    timer_d = timer_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= 3'd0;
            timer_q  <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
        end
    end

    assign bus.mem_avalid_o = busy;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wen_o    = busy & wen_q;
    assign bus.mem_wdata_o  = wdata_q;

    assign bus.ifu_rvalid_o = ifu_busy & resp;
    assign bus.ifu_err_o    = ifu_busy & tmo;
    assign bus.ifu_rdata_o  = (ifu_busy & done) ? bus.mem_rdata : '0;

    assign bus.lsu_rvalid_o = lsu_busy & ~wen_q & resp;
    assign bus.lsu_wready_o = lsu_busy & wen_q & resp;
    assign bus.lsu_err_o    = lsu_busy & tmo;
    assign bus.lsu_rdata_o  = (lsu_busy & ~wen_q & done) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_ysyx_mem_arb.sv
// Directed bench for ysyx_mem_arb: arbitration order, streak cap,
// watchdog timeout, stray strobes and asynchronous reset.
module tb_ysyx_mem_arb;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    ysyx_mem_arb_if #(.BIT_W(32)) bus ();

    ysyx_mem_arb #(
        .BIT_W(32),
        .LSU_MAX_STREAK(4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic quiet(input string tag);
        chk({tag, ":ifu_rvalid"}, 32'(bus.ifu_rvalid_o), 32'd0);
        chk({tag, ":lsu_rvalid"}, 32'(bus.lsu_rvalid_o), 32'd0);
        chk({tag, ":lsu_wready"}, 32'(bus.lsu_wready_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ifu_avalid = 1'b0; bus.ifu_addr  = '0;
        bus.lsu_avalid = 1'b0; bus.lsu_addr  = '0;
        bus.lsu_wen    = 1'b0; bus.lsu_wdata = '0;
        bus.mem_rvalid = 1'b0; bus.mem_wready = 1'b0;
        bus.mem_rdata  = '0;
        nx(); nx(); #1;
        chk("rst:mem_avalid", 32'(bus.mem_avalid_o), 32'd0);
        chk("rst:mem_wen", 32'(bus.mem_wen_o), 32'd0);
        chk("rst:mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst:mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst:ifu_rdata", bus.ifu_rdata_o, 32'd0);
        quiet("rst");
        rst = 1'b0;

        // IFU-only read, memory answers on the 3rd busy cycle
        nx();
        bus.ifu_avalid = 1'b1; bus.ifu_addr = 32'h8000_0000;
        nx(); #1;
        chk("t1:avalid", 32'(bus.mem_avalid_o), 32'd1);
        chk("t1:addr", bus.mem_addr_o, 32'h8000_0000);
        chk("t1:wen", 32'(bus.mem_wen_o), 32'd0);
        nx(); #1;
        quiet("t1:wait");
        nx();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013;
        #1;
        chk("t1:ifu_rvalid", 32'(bus.ifu_rvalid_o), 32'd1);
        chk("t1:ifu_rdata", bus.ifu_rdata_o, 32'h13);
        chk("t1:ifu_err", 32'(bus.ifu_err_o), 32'd0);
        chk("t1:lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'd0);
        chk("t1:lsu_rdata", bus.lsu_rdata_o, 32'd0);
        nx();
        bus.mem_rvalid = 1'b0; bus.ifu_avalid = 1'b0;
        #1;
        chk("t1:idle", 32'(bus.mem_avalid_o), 32'd0);
        quiet("t1:idle");

        // simultaneous requests: LSU store first, then IFU
        nx();
        bus.ifu_avalid = 1'b1; bus.ifu_addr = 32'h8000_0004;
        bus.lsu_avalid = 1'b1; bus.lsu_wen = 1'b1;
        bus.lsu_addr = 32'h8000_1000; bus.lsu_wdata = 32'h1234_5678;
        nx();
        bus.mem_wready = 1'b1;
        #1;
        chk("t2:addr", bus.mem_addr_o, 32'h8000_1000);
        chk("t2:wen", 32'(bus.mem_wen_o), 32'd1);
        chk("t2:wdata", bus.mem_wdata_o, 32'h1234_5678);
        chk("t2:wready", 32'(bus.lsu_wready_o), 32'd1);
        chk("t2:lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'd0);
        chk("t2:ifu_rvalid", 32'(bus.ifu_rvalid_o), 32'd0);
        nx();
        bus.mem_wready = 1'b0; bus.lsu_avalid = 1'b0; bus.lsu_wen = 1'b0;
        #1;
        chk("t2:gap", 32'(bus.mem_avalid_o), 32'd0);
        nx();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_00AA;
        #1;
        chk("t2:ifu_addr", bus.mem_addr_o, 32'h8000_0004);
        chk("t2:ifu_wen", 32'(bus.mem_wen_o), 32'd0);
        chk("t2:ifu_rvalid", 32'(bus.ifu_rvalid_o), 32'd1);
        chk("t2:ifu_rdata", bus.ifu_rdata_o, 32'hAA);
        nx();
        bus.mem_rvalid = 1'b0; bus.ifu_avalid = 1'b0;

        // streak cap: L,L,L,L,I,L with zero-wait memory
        nx();
        bus.lsu_avalid = 1'b1; bus.lsu_addr = 32'h0000_0100;
        bus.ifu_avalid = 1'b1; bus.ifu_addr = 32'h0000_0200;
        for (int i = 0; i < 6; i++) begin
            nx();
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'(i + 1);
            #1;
            chk($sformatf("t3:addr%0d", i), bus.mem_addr_o,
                (i == 4) ? 32'h200 : 32'h100);
            chk($sformatf("t3:ifu%0d", i), 32'(bus.ifu_rvalid_o),
                (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t3:lsu%0d", i), 32'(bus.lsu_rvalid_o),
                (i == 4) ? 32'd0 : 32'd1);
            nx();
            bus.mem_rvalid = 1'b0;
            #1;
            chk($sformatf("t3:gap%0d", i), 32'(bus.mem_avalid_o), 32'd0);
        end
        bus.lsu_avalid = 1'b0; bus.ifu_avalid = 1'b0;

        // watchdog: no response, error on the 8th busy cycle
        nx();
        bus.lsu_avalid = 1'b1; bus.lsu_addr = 32'h0000_0300;
        for (int c = 1; c <= 8; c++) begin
            nx(); #1;
            chk($sformatf("t4:rvalid%0d", c), 32'(bus.lsu_rvalid_o),
                (c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("t4:err%0d", c), 32'(bus.lsu_err_o),
                (c == 8) ? 32'd1 : 32'd0);
        end
        chk("t4:rdata", bus.lsu_rdata_o, 32'd0);
        nx();
        bus.lsu_avalid = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t4:idle", 32'(bus.mem_avalid_o), 32'd0);
        quiet("t4:late");
        nx();
        bus.mem_rvalid = 1'b0;

        // stray write ack during a load is ignored
        nx();
        bus.lsu_avalid = 1'b1; bus.lsu_addr = 32'h0000_0400;
        nx();
        bus.mem_wready = 1'b1;
        #1;
        quiet("t5:stray");
        nx();
        bus.mem_wready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0055;
        #1;
        chk("t5:rvalid", 32'(bus.lsu_rvalid_o), 32'd1);
        chk("t5:rdata", bus.lsu_rdata_o, 32'h55);
        chk("t5:wready", 32'(bus.lsu_wready_o), 32'd0);
        nx();
        bus.mem_rvalid = 1'b0; bus.lsu_avalid = 1'b0;

        // asynchronous reset in the middle of an IFU transaction
        nx();
        bus.ifu_avalid = 1'b1; bus.ifu_addr = 32'h0000_0500;
        nx(); #1;
        chk("t6:busy", 32'(bus.mem_avalid_o), 32'd1);
        #1;
        rst = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0066;
        #1;
        chk("t6:avalid", 32'(bus.mem_avalid_o), 32'd0);
        chk("t6:addr", bus.mem_addr_o, 32'd0);
        quiet("t6:rst");
        nx();
        rst = 1'b0; bus.mem_rvalid = 1'b0; bus.ifu_addr = 32'h0000_0504;
        nx();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077;
        #1;
        chk("t6:addr2", bus.mem_addr_o, 32'h0000_0504);
        chk("t6:rvalid2", 32'(bus.ifu_rvalid_o), 32'd1);
        chk("t6:rdata2", bus.ifu_rdata_o, 32'h77);
        nx();
        bus.mem_rvalid = 1'b0; bus.ifu_avalid = 1'b0;
        #1;
        chk("t6:end", 32'(bus.mem_avalid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_mem_arb.md
Name: ysyx_mem_arb

Overview:
- Single-port memory arbiter shared by the instruction fetch unit (IFU) and the execute-stage load/store path (LSU).
- Grants one requester at a time and keeps one outstanding transaction.
- Routes the read-data and write-ack response back to the granted requester.
- LSU has priority, with an anti-starvation cap for the IFU and a response-timeout watchdog.
- Sits between the ifu/exu and the core's bus master.

Parameters:
BIT_W, 32, address/data width
LSU_MAX_STREAK, 4, max consecutive LSU grants while IFU waits (1..7)
TIMEOUT_CYC, 255, cycles without memory response before error completion; 0 disables (max 255, 8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ifu_avalid  in  1  IFU read request; held with ifu_addr until ifu_rvalid_o
ifu_addr  in  BIT_W  IFU fetch address
ifu_rvalid_o  out  1  IFU response pulse
ifu_rdata_o  out  BIT_W  IFU read data
ifu_err_o  out  1  qualifies ifu_rvalid_o: timeout
lsu_avalid  in  1  LSU request; held with address/controls until response
lsu_addr  in  BIT_W  LSU address
lsu_wen  in  1  1=store, 0=load
lsu_wdata  in  BIT_W  store data
lsu_rvalid_o  out  1  load response pulse
lsu_wready_o  out  1  store ack pulse
lsu_rdata_o  out  BIT_W  load data
lsu_err_o  out  1  qualifies lsu_rvalid_o/lsu_wready_o: timeout
mem_avalid_o  out  1  memory request valid
mem_addr_o  out  BIT_W  memory address
mem_wen_o  out  1  memory write enable
mem_wdata_o  out  BIT_W  memory write data
mem_rvalid  in  1  memory read data valid
mem_wready  in  1  memory write complete
mem_rdata  in  BIT_W  memory read data

Behaviour:
- Reset (async, any cycle incl. mid-transaction):
  - state=IDLE; streak=0; timer=0.
  - mem_avalid_o, mem_wen_o and all response/err outputs 0.
  - mem_addr_o and mem_wdata_o 0.
  - In-flight transaction abandoned with no response.
- States: IDLE, IFU_BUSY, LSU_BUSY.
- IDLE arbitration, evaluated each cycle from the current inputs:
  - Both requesting: LSU wins unless streak==LSU_MAX_STREAK, then IFU wins.
  - Only one requesting: it wins.
  - None requesting: stay in IDLE.
- Grant at the clock edge:
  - Latch addr; latch wen/wdata (IFU: wen=0).
  - mem_avalid_o=1 from the next cycle.
  - Go to *_BUSY; timer=0.
- Streak counter:
  - LSU grant while ifu_avalid=1: streak+1, saturating.
  - LSU grant with ifu_avalid=0: streak=0.
  - IFU grant: streak=0.
- BUSY completion:
  - Read completes on mem_rvalid; write completes on mem_wready. The non-matching strobe is ignored.
  - Completion cycle (combinational): pulse the granted requester's rvalid/wready; rdata = mem_rdata; err=0.
  - Next edge: mem_avalid_o=0; state=IDLE.
- Latency: request seen at edge N → mem_avalid_o at N+1. A zero-wait memory responds in the N+1 cycle, giving a 1-cycle round trip plus 1 IDLE cycle between transactions.
- Timeout (TIMEOUT_CYC>0):
  - timer increments each BUSY cycle without completion.
  - When timer==TIMEOUT_CYC-1 with no completion, that cycle pulses the response with err=1 and rdata=0, then returns to IDLE.
  - A real completion in the same cycle wins with err=0.
  - A memory response arriving in IDLE is dropped.
- Response outputs are 0 when not pulsing; rdata outputs are 0 when their rvalid=0.
- Requester dropping avalid while BUSY does not cancel the transaction; the response still pulses.
- mem_addr_o, mem_wen_o and mem_wdata_o stay stable while mem_avalid_o=1.

Test Plan:
- IFU-only read at 0x8000_0000, memory rvalid 2 cycles after mem_avalid_o, rdata 0x0000_0013 → ifu_rvalid_o one pulse with 0x13, err=0, lsu outputs quiet, IDLE next cycle.
- IFU and LSU (store 0x1234_5678 → 0x8000_1000) requesting in the same cycle → LSU granted first, mem_wen_o=1, lsu_wready_o pulse; IFU granted immediately after.
- LSU continuously requesting with IFU pending, LSU_MAX_STREAK=4 → grant order L,L,L,L,I,L…
- Memory never responds, TIMEOUT_CYC=8 → lsu_rvalid_o=1, lsu_err_o=1, rdata 0 on the 8th BUSY cycle; a late mem_rvalid in IDLE produces no pulse.
- Stray mem_wready during an LSU load → ignored; only mem_rvalid completes it.
- rst asserted mid-IFU_BUSY between edges → mem_avalid_o=0 immediately, no response; a fresh request after release is served normally.
